er_guard: RTL and testbench
===========================

ER_GUARD -- requirements
Module: er_guard

Interface
REQ-001 Parameter NUM_ER, 2, number of independently monitored execution regions (1..8).
REQ-002 Parameter ADDR_W, 16, width of pc and region bounds.
REQ-003 Parameter CNT_W, 4, width of each per-region abort counter.
REQ-004 Parameter EXIT_CHK, 1, when 1 a premature exit from a region aborts it.
REQ-005 clk  input  1  single clock, all state updates on its rising edge.
REQ-006 puc_rst  input  1  reset, synchronous and active-high.
REQ-007 pc  input  ADDR_W  current program counter.
REQ-008 irq  input  1  interrupt request/acceptance indication.
REQ-009 dma_en  input  1  DMA access active this cycle.
REQ-010 er_min  input  NUM_ER*ADDR_W  region lower bounds, region i at bits [i*ADDR_W +: ADDR_W].
REQ-011 er_max  input  NUM_ER*ADDR_W  region upper bounds, same packing.
REQ-012 irq_chk_en  input  NUM_ER  per-region enable for irq as violation.
REQ-013 dma_chk_en  input  NUM_ER  per-region enable for dma_en as violation.
REQ-014 clr_cnt  input  NUM_ER  per-region one-cycle counter clear.
REQ-015 exec  output  NUM_ER  per-region "execution valid" flag.
REQ-016 cfg_err  output  NUM_ER  region i has er_min > er_max.
REQ-017 abort_cnt  output  NUM_ER*CNT_W  per-region saturating abort counters.
REQ-018 last_cause  output  NUM_ER*2  cause of most recent abort: 00 none, 01 dma, 10 irq, 11 early exit.

Function
REQ-019 in_er[i] SHALL be unsigned inclusive compare: er_min[i] <= pc <= er_max[i].
REQ-020 viol[i] SHALL be in_er[i] && ((dma_en && dma_chk_en[i]) || (irq && irq_chk_en[i])).
REQ-021 early_exit[i] SHALL be EXIT_CHK && state EXEC && pc_q in region i && pc_q != er_max[i] && !in_er[i], pc_q being pc registered one cycle earlier.
REQ-022 Each region SHALL run a two-state FSM ABORT/EXEC; ABORT->EXEC when pc == er_min[i] && !viol[i] && !cfg_err[i]; EXEC->ABORT on viol[i] || early_exit[i] || cfg_err[i]; otherwise hold.
REQ-023 exec[i] SHALL be registered and equal 1 exactly when the region FSM is in EXEC (updated on the same edge as the state, one-cycle latency from pc).
REQ-024 Entry at pc == er_min[i] with viol[i] asserted SHALL leave the region in ABORT.
REQ-025 cfg_err[i] SHALL be combinational; while set the region SHALL be forced to ABORT without counting.
REQ-026 Each EXEC->ABORT transition not caused by cfg_err SHALL increment abort_cnt[i], saturating at 2^CNT_W-1.
REQ-027 clr_cnt[i] SHALL zero abort_cnt[i]; clear and increment in the same cycle SHALL yield 1.
REQ-028 On each counted abort last_cause[i] SHALL load the cause with priority dma > irq > early exit; otherwise it holds.
REQ-029 Regions SHALL be fully independent; overlapping regions SHALL each evaluate the same pc.

Reset
REQ-030 While puc_rst is high at a clock edge: all FSMs ABORT, exec 0, abort_cnt 0, last_cause 00, pc_q 0.
REQ-031 Reset mid-EXEC SHALL drop exec to 0 on that edge without counting; re-entry requires pc == er_min after reset release.

Structure
REQ-032 State encodings (ABORT=0, EXEC=1) and cause codes SHALL live in shared package er_guard_pkg.
REQ-033 Per-region logic SHALL be one sub-module er_guard_ch instantiated NUM_ER times via generate; pc_q register shared in the top.

Verification
REQ-034 Region0 0xE000-0xE0FF, dma_chk_en=1: pc 0xE000 then sequential -> exec[0]=1 one cycle after 0xE000, holds through 0xE0FF.
REQ-035 In EXEC, dma_en=1 at pc 0xE010 -> exec[0]=0 next edge, abort_cnt[0]=1, last_cause[0]=01; re-entry at 0xE000 restores exec.
REQ-036 irq=1 with irq_chk_en[0]=0 at 0xE020 -> exec stays 1; with irq_chk_en[0]=1 -> abort, last_cause=10.
REQ-037 Jump 0xE050 -> 0x4000 in EXEC, EXIT_CHK=1 -> abort, cause 11; exit from 0xE0FF -> no abort, count unchanged.
REQ-038 CNT_W=2, five aborts -> abort_cnt=3; clr_cnt with simultaneous abort -> 1; er_min=0xF000 > er_max=0xE000 -> cfg_err=1, exec 0.
REQ-039 puc_rst asserted mid-EXEC -> exec 0, counters 0 next edge; region1 unaffected by region0 events before reset.

Source files
------------

// File: rtl/er_guard_pkg.sv
// Shared state encodings and abort cause codes for the execution-region guard.
package er_guard_pkg;

  typedef enum logic {
    ST_ABORT = 1'b0,
    ST_EXEC  = 1'b1
  } er_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_DMA  = 2'b01,
    CAUSE_IRQ  = 2'b10,
    CAUSE_EXIT = 2'b11
  } er_cause_e;

endpackage

// File: rtl/er_guard_ch.sv
// One monitored execution region: bounds check, ABORT/EXEC FSM, saturating
// abort counter and cause capture.
module er_guard_ch
  import er_guard_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 4,
  parameter int EXIT_CHK = 1
) (
  input  logic              clk,
  input  logic              puc_rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_prev,
  input  logic              irq,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] er_min,
  input  logic [ADDR_W-1:0] er_max,
  input  logic              irq_chk_en,
  input  logic              dma_chk_en,
  input  logic              clr_cnt,
  output logic              exec,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  abort_cnt,
  output logic [1:0]        last_cause
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  er_state_e        state_q, state_d;
  logic             exec_q, exec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  er_cause_e        cause_q, cause_d;

  logic in_er, prev_in_er, dma_hit, irq_hit, viol, early_exit, count_abort;

  assign cfg_err    = (er_min > er_max);
  assign in_er      = (pc >= er_min) && (pc <= er_max);
  assign prev_in_er = (pc_prev >= er_min) && (pc_prev <= er_max);
  assign dma_hit    = in_er && dma_en && dma_chk_en;
  assign irq_hit    = in_er && irq && irq_chk_en;
  assign viol       = dma_hit || irq_hit;
  // Leaving through the last address is the legitimate exit path.
  assign early_exit = (EXIT_CHK != 0) && (state_q == ST_EXEC) && prev_in_er
                      && (pc_prev != er_max) && !in_er;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    count_abort = 1'b0;
    if (state_q == ST_ABORT) begin
      if ((pc == er_min) && !viol && !cfg_err) begin
        state_d = ST_EXEC;
      end
    end else begin
      if (cfg_err) begin
        state_d = ST_ABORT;
      end else if (viol || early_exit) begin
        state_d     = ST_ABORT;
        count_abort = 1'b1;
      end
    end

    if (count_abort) begin
      cause_d = dma_hit ? CAUSE_DMA : (irq_hit ? CAUSE_IRQ : CAUSE_EXIT);
    end

    exec_d = (state_d == ST_EXEC);

    // A clear coinciding with an abort leaves that abort counted.
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = count_abort ? CNT_ONE : '0;
    end else if (count_abort && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state_q <= ST_ABORT;
      exec_q  <= 1'b0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      exec_q  <= exec_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign exec       = exec_q;
  assign abort_cnt  = cnt_q;
  assign last_cause = cause_q;

endmodule

// File: rtl/er_guard.sv
// Execution-region guard: NUM_ER independent region monitors sharing one
// registered copy of the previous program counter.
module er_guard
  import er_guard_pkg::*;
#(
  parameter int NUM_ER   = 2,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 4,
  parameter int EXIT_CHK = 1
) (
  input  logic                     clk,
  input  logic                     puc_rst,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     irq,
  input  logic                     dma_en,
  input  logic [NUM_ER*ADDR_W-1:0] er_min,
  input  logic [NUM_ER*ADDR_W-1:0] er_max,
  input  logic [NUM_ER-1:0]        irq_chk_en,
  input  logic [NUM_ER-1:0]        dma_chk_en,
  input  logic [NUM_ER-1:0]        clr_cnt,
  output logic [NUM_ER-1:0]        exec,
  output logic [NUM_ER-1:0]        cfg_err,
  output logic [NUM_ER*CNT_W-1:0]  abort_cnt,
  output logic [NUM_ER*2-1:0]      last_cause
);

  logic [ADDR_W-1:0] pc_prev_q, pc_prev_d;

  assign pc_prev_d = pc;

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      pc_prev_q <= '0;
    end else begin
      pc_prev_q <= pc_prev_d;
    end
  end

  for (genvar gi = 0; gi < NUM_ER; gi++) begin : g_ch
    er_guard_ch #(
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W),
      .EXIT_CHK(EXIT_CHK)
    ) u_ch (
      .clk       (clk),
      .puc_rst   (puc_rst),
      .pc        (pc),
      .pc_prev   (pc_prev_q),
      .irq       (irq),
      .dma_en    (dma_en),
      .er_min    (er_min[gi*ADDR_W +: ADDR_W]),
      .er_max    (er_max[gi*ADDR_W +: ADDR_W]),
      .irq_chk_en(irq_chk_en[gi]),
      .dma_chk_en(dma_chk_en[gi]),
      .clr_cnt   (clr_cnt[gi]),
      .exec      (exec[gi]),
      .cfg_err   (cfg_err[gi]),
      .abort_cnt (abort_cnt[gi*CNT_W +: CNT_W]),
      .last_cause(last_cause[gi*2 +: 2])
    );
  end

endmodule

// File: tb/tb_er_guard.sv
// Directed plus randomized bench for er_guard, checked against a behavioural
// per-region model built from the region rules.
module tb_er_guard;

  localparam int NE = 2;
  localparam int AW = 16;
  localparam int CW = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          puc_rst;
  logic [AW-1:0] pc;
  logic          irq;
  logic          dma_en;
  logic [NE*AW-1:0] er_min, er_max;
  logic [NE-1:0] irq_chk_en, dma_chk_en, clr_cnt;
  logic [NE-1:0] exec, cfg_err;
  logic [NE*CW-1:0] abort_cnt;
  logic [NE*2-1:0]  last_cause;

  logic [AW-1:0] mn [NE];
  logic [AW-1:0] mx [NE];

  assign er_min = {mn[1], mn[0]};
  assign er_max = {mx[1], mx[0]};

  always #5 clk = ~clk;

  er_guard #(.NUM_ER(NE), .ADDR_W(AW), .CNT_W(CW), .EXIT_CHK(1)) dut (
    .clk(clk), .puc_rst(puc_rst), .pc(pc), .irq(irq), .dma_en(dma_en),
    .er_min(er_min), .er_max(er_max), .irq_chk_en(irq_chk_en),
    .dma_chk_en(dma_chk_en), .clr_cnt(clr_cnt), .exec(exec),
    .cfg_err(cfg_err), .abort_cnt(abort_cnt), .last_cause(last_cause)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one "executing" flag, abort tally and last cause per region.
  bit            m_exec [NE];
  int            m_cnt  [NE];
  int            m_cause[NE];
  logic [AW-1:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit inside_rng(input int r, input logic [AW-1:0] a);
    return (a >= mn[r]) && (a <= mx[r]);
  endfunction

  task automatic model_step();
    for (int r = 0; r < NE; r++) begin
      bit cfg, inr, dh, ih, ee, counted;
      cfg = mn[r] > mx[r];
      inr = inside_rng(r, pc);
      dh  = inr && dma_en && dma_chk_en[r];
      ih  = inr && irq && irq_chk_en[r];
      ee  = m_exec[r] && inside_rng(r, m_prev) && (m_prev != mx[r]) && !inr;
      counted = 1'b0;
      if (puc_rst) begin
        m_exec[r] = 1'b0; m_cnt[r] = 0; m_cause[r] = 0;
      end else begin
        if (cfg) begin
          m_exec[r] = 1'b0;
        end else if (!m_exec[r]) begin
          m_exec[r] = (pc == mn[r]) && !(dh || ih);
        end else if (dh || ih || ee) begin
          m_exec[r] = 1'b0;
          counted = 1'b1;
          m_cause[r] = dh ? 1 : (ih ? 2 : 3);
        end
        if (clr_cnt[r]) m_cnt[r] = counted ? 1 : 0;
        else if (counted && m_cnt[r] < CMAX) m_cnt[r] = m_cnt[r] + 1;
      end
    end
    m_prev = puc_rst ? '0 : pc;
  endtask

  task automatic cyc(input logic [AW-1:0] p, input logic i, input logic d,
                     input logic [NE-1:0] c, input logic r);
    logic [NE-1:0] e_exec, e_cfg;
    logic [NE*CW-1:0] e_cnt;
    logic [NE*2-1:0]  e_cause;
    pc = p; irq = i; dma_en = d; clr_cnt = c; puc_rst = r;
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NE; k++) begin
      e_exec[k] = m_exec[k];
      e_cfg[k]  = mn[k] > mx[k];
      e_cnt[k*CW +: CW]  = CW'(m_cnt[k]);
      e_cause[k*2 +: 2]  = 2'(m_cause[k]);
    end
    chk("exec", 32'(exec), 32'(e_exec));
    chk("cfg_err", 32'(cfg_err), 32'(e_cfg));
    chk("abort_cnt", 32'(abort_cnt), 32'(e_cnt));
    chk("last_cause", 32'(last_cause), 32'(e_cause));
    $display("cyc pc=%h irq=%b dma=%b clr=%b rst=%b -> exec=%b cfg=%b cnt=%h cause=%h",
             p, i, d, c, r, exec, cfg_err, abort_cnt, last_cause);
  endtask

  initial begin
    mn[0] = 16'hE000; mx[0] = 16'hE0FF;
    mn[1] = 16'hE080; mx[1] = 16'hE1FF;
    dma_chk_en = 2'b01; irq_chk_en = 2'b00;
    m_prev = '0;
    for (int r = 0; r < NE; r++) begin
      m_exec[r] = 1'b0; m_cnt[r] = 0; m_cause[r] = 0;
    end

    // Reset state
    cyc(16'h0000, 0, 0, 2'b00, 1);
    cyc(16'h0000, 0, 0, 2'b00, 1);
    chk("rst_exec", 32'(exec), 32'h0);
    chk("rst_cnt", 32'(abort_cnt), 32'h0);
    chk("rst_cause", 32'(last_cause), 32'h0);
    cyc(16'h1000, 0, 0, 2'b00, 0);

    // Sequential walk through region 0
    for (int a = 16'hE000; a <= 16'hE0FF; a++) begin
      cyc(16'(a), 0, 0, 2'b00, 0);
      if (a == 16'hE000) chk("entry_exec0", 32'(exec[0]), 32'h1);
    end
    chk("walk_exec0", 32'(exec[0]), 32'h1);
    cyc(16'hE100, 0, 0, 2'b00, 0);
    chk("maxexit_cnt0", 32'(abort_cnt[1:0]), 32'h0);

    // DMA abort and re-entry
    cyc(16'hE000, 0, 0, 2'b00, 0);
    cyc(16'hE010, 0, 1, 2'b00, 0);
    chk("dma_exec0", 32'(exec[0]), 32'h0);
    chk("dma_cnt0", 32'(abort_cnt[1:0]), 32'h1);
    chk("dma_cause0", 32'(last_cause[1:0]), 32'h1);
    cyc(16'hE000, 0, 0, 2'b00, 0);
    chk("reentry_exec0", 32'(exec[0]), 32'h1);

    // IRQ masked, then enabled
    cyc(16'hE020, 1, 0, 2'b00, 0);
    chk("irq_masked_exec0", 32'(exec[0]), 32'h1);
    irq_chk_en = 2'b01;
    cyc(16'hE021, 1, 0, 2'b00, 0);
    chk("irq_exec0", 32'(exec[0]), 32'h0);
    chk("irq_cause0", 32'(last_cause[1:0]), 32'h2);
    irq_chk_en = 2'b00;

    // Early exit
    cyc(16'hE000, 0, 0, 2'b00, 0);
    cyc(16'hE050, 0, 0, 2'b00, 0);
    cyc(16'h4000, 0, 0, 2'b00, 0);
    chk("ee_exec0", 32'(exec[0]), 32'h0);
    chk("ee_cause0", 32'(last_cause[1:0]), 32'h3);
    chk("ee_cnt0", 32'(abort_cnt[1:0]), 32'h3);

    // Exit from last address is not an abort
    cyc(16'h3000, 0, 0, 2'b01, 0);
    chk("clr_cnt0", 32'(abort_cnt[1:0]), 32'h0);
    cyc(16'hE000, 0, 0, 2'b00, 0);
    cyc(16'hE0FF, 0, 0, 2'b00, 0);
    cyc(16'h4000, 0, 0, 2'b00, 0);
    chk("legal_exit_exec0", 32'(exec[0]), 32'h1);
    chk("legal_exit_cnt0", 32'(abort_cnt[1:0]), 32'h0);

    // Saturation, then clear with simultaneous abort
    for (int n = 0; n < 5; n++) begin
      cyc(16'hE000, 0, 0, 2'b00, 0);
      cyc(16'hE001, 0, 1, 2'b00, 0);
    end
    chk("sat_cnt0", 32'(abort_cnt[1:0]), 32'h3);
    cyc(16'hE000, 0, 0, 2'b00, 0);
    cyc(16'hE001, 0, 1, 2'b01, 0);
    chk("clr_inc_cnt0", 32'(abort_cnt[1:0]), 32'h1);

    // Region independence and reset mid-EXEC
    cyc(16'hE000, 0, 0, 2'b00, 0);
    cyc(16'hE080, 0, 0, 2'b00, 0);
    chk("both_exec", 32'(exec), 32'h3);
    cyc(16'hE082, 0, 1, 2'b00, 0);
    chk("indep_exec", 32'(exec), 32'h2);
    cyc(16'hE083, 0, 0, 2'b00, 1);
    chk("rst_mid_exec", 32'(exec), 32'h0);
    chk("rst_mid_cnt", 32'(abort_cnt), 32'h0);
    cyc(16'hE084, 0, 0, 2'b00, 0);
    chk("post_rst_exec", 32'(exec), 32'h0);

    // Inverted bounds
    mn[0] = 16'hF000; mx[0] = 16'hE000;
    cyc(16'hF000, 0, 0, 2'b00, 0);
    chk("cfg_err", 32'(cfg_err), 32'h1);
    chk("cfg_exec0", 32'(exec[0]), 32'h0);
    mn[0] = 16'hE000; mx[0] = 16'hE0FF;

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      logic [AW-1:0] np;
      int sel;
      if (t % 100 == 0) begin
        for (int r = 0; r < NE; r++) begin
          case ($urandom_range(0, 3))
            0: begin mn[r] = 16'hE000; mx[r] = 16'hE0FF; end
            1: begin mn[r] = 16'hE080; mx[r] = 16'hE1FF; end
            2: begin mn[r] = 16'hE100; mx[r] = 16'hE10F; end
            default: begin mn[r] = 16'hF000; mx[r] = 16'hE000; end
          endcase
        end
      end
      if (t % 50 == 0) begin
        dma_chk_en = 2'($urandom);
        irq_chk_en = 2'($urandom);
      end
      sel = $urandom_range(0, 9);
      if (sel < 5)       np = pc + 16'h1;
      else if (sel == 5) np = mn[$urandom_range(0, 1)];
      else if (sel == 6) np = mx[$urandom_range(0, 1)];
      else if (sel < 9)  np = 16'hE000 + 16'($urandom_range(0, 16'h1FF));
      else               np = 16'($urandom);
      cyc(np, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)},
          ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
